alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 53 +++++
 rtl/alu_arbiter.sv | 108 ++++++++++
 tb/tb_alu_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// ============================================================================
// alu_arbiter_if : requester, response and shared-ALU signals of alu_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

interface alu_arbiter_if #(
  parameter int Bits = 64
);
  logic            r0_valid;
  logic            r0_ready;
  logic [Bits-1:0] r0_A;
  logic [Bits-1:0] r0_B;
  logic [1:0]      r0_sel;
  logic            r0_resp_valid;
  logic            r0_resp_ready;

  logic            r1_valid;
  logic            r1_ready;
  logic [Bits-1:0] r1_A;
  logic [Bits-1:0] r1_B;
  logic [1:0]      r1_sel;
  logic            r1_resp_valid;
  logic            r1_resp_ready;

  logic [Bits-1:0] resp_resultado;
  logic            resp_zero;

  logic [Bits-1:0] alu_A;
  logic [Bits-1:0] alu_B;
  logic [1:0]      alu_sel;
  logic [Bits-1:0] alu_resultado;

  logic            busy;

  modport slave (
    input  r0_valid, r0_A, r0_B, r0_sel, r0_resp_ready,
    input  r1_valid, r1_A, r1_B, r1_sel, r1_resp_ready,
    input  alu_resultado,
    output r0_ready, r0_resp_valid, r1_ready, r1_resp_valid,
    output resp_resultado, resp_zero, alu_A, alu_B, alu_sel, busy
  );

  modport master (
    output r0_valid, r0_A, r0_B, r0_sel, r0_resp_ready,
    output r1_valid, r1_A, r1_B, r1_sel, r1_resp_ready,
    output alu_resultado,
    input  r0_ready, r0_resp_valid, r1_ready, r1_resp_valid,
    input  resp_resultado, resp_zero, alu_A, alu_B, alu_sel, busy
  );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// alu_arbiter : two-requester round-robin front end for one shared ALU
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_arbiter #(
  parameter int Bits = 64
) (
  input  wire logic     clk,
  input  wire logic     reset,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic            ptr;
  logic            gnt_id;
  logic [Bits-1:0] op_a;
  logic [Bits-1:0] op_b;
  logic [1:0]      op_sel;
  logic [Bits-1:0] result;
  logic            zero;
  logic            r0_rv;
  logic            r1_rv;
  logic            grant_r0;
  logic            grant_r1;
  logic            resp_take;

  // Ready is combinational on valid so acceptance happens in the same cycle.
  always_comb begin
    grant_r0 = 1'b0;
    grant_r1 = 1'b0;
    if (state == IDLE && !reset) begin
      if (bus.r0_valid && bus.r1_valid) begin
        grant_r0 = !ptr;
        grant_r1 = ptr;
      end else begin
        grant_r0 = bus.r0_valid;
        grant_r1 = bus.r1_valid;
      end
    end
  end

  assign resp_take          = gnt_id ? bus.r1_resp_ready : bus.r0_resp_ready;
  assign bus.r0_ready       = grant_r0;
  assign bus.r1_ready       = grant_r1;
  assign bus.r0_resp_valid  = r0_rv;
  assign bus.r1_resp_valid  = r1_rv;
  assign bus.resp_resultado = result;
  assign bus.resp_zero      = zero;
  assign bus.alu_A          = op_a;
  assign bus.alu_B          = op_b;
  assign bus.alu_sel        = op_sel;
  assign bus.busy           = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= 1'b0;
      gnt_id <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      op_sel <= 2'b00;
      result <= '0;
      zero   <= 1'b0;
      r0_rv  <= 1'b0;
      r1_rv  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_r0 || grant_r1) begin
            op_a   <= grant_r1 ? bus.r1_A   : bus.r0_A;
            op_b   <= grant_r1 ? bus.r1_B   : bus.r0_B;
            op_sel <= grant_r1 ? bus.r1_sel : bus.r0_sel;
            gnt_id <= grant_r1;
            ptr    <= grant_r0;
            state  <= EXEC;
          end
        end
        EXEC: begin
          result <= bus.alu_resultado;
          // Only subtract reports a zero flag; other ops force it low.
          zero   <= (op_sel == 2'b01) && (bus.alu_resultado == '0);
          r0_rv  <= !gnt_id;
          r1_rv  <= gnt_id;
          state  <= RESP;
        end
        RESP: begin
          if (resp_take) begin
            r0_rv <= 1'b0;
            r1_rv <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// tb_alu_arbiter : directed scenarios plus randomized transaction-level model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  alu_arbiter_if #(.Bits(64)) bus ();

  alu_arbiter #(.Bits(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] alu_fn(input logic [63:0] a, input logic [63:0] b,
                                         input logic [1:0] sel);
    case (sel)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  // Shared ALU lives outside the arbiter.
  always_comb bus.alu_resultado = alu_fn(bus.alu_A, bus.alu_B, bus.alu_sel);

  function automatic logic [63:0] rnd();
    case ($urandom_range(0, 3))
      0:       return 64'd0;
      1:       return 64'($urandom_range(0, 15));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic idle_inputs();
    bus.r0_valid = 0; bus.r0_A = 0; bus.r0_B = 0; bus.r0_sel = 0; bus.r0_resp_ready = 1;
    bus.r1_valid = 0; bus.r1_A = 0; bus.r1_B = 0; bus.r1_sel = 0; bus.r1_resp_ready = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    bus.r0_valid = 1; bus.r1_valid = 1;
    bus.r0_A = 64'h55; bus.r1_B = 64'hAA; bus.r0_sel = 2'b11;
    @(negedge clk);
    @(negedge clk);
    #1;
    total++;
    if ({bus.r0_ready, bus.r1_ready} !== 2'b00) begin
      bad++; $display("FAIL reset_ready: got %b want 00", {bus.r0_ready, bus.r1_ready});
    end
    total++;
    if ({bus.r0_resp_valid, bus.r1_resp_valid, bus.busy, bus.resp_zero} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: got %b want 0000",
                      {bus.r0_resp_valid, bus.r1_resp_valid, bus.busy, bus.resp_zero});
    end
    total++;
    if (bus.resp_resultado !== 64'd0) begin
      bad++; $display("FAIL reset_result: got %h want 0", bus.resp_resultado);
    end
    total++;
    if ({bus.alu_A, bus.alu_B, bus.alu_sel} !== 130'd0) begin
      bad++; $display("FAIL reset_alu: got A=%h B=%h sel=%b want zeros", bus.alu_A, bus.alu_B, bus.alu_sel);
    end
    reset = 0;
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_single();
    bus.r0_valid = 1; bus.r0_A = 64'd5; bus.r0_B = 64'd3; bus.r0_sel = 2'b00;
    #1;
    total++;
    if ({bus.r0_ready, bus.r1_ready} !== 2'b10) begin
      bad++; $display("FAIL single_ready: got %b want 10", {bus.r0_ready, bus.r1_ready});
    end
    @(negedge clk);
    bus.r0_valid = 0; bus.r0_A = 64'd99;
    #1;
    total++;
    if (bus.busy !== 1'b1 || bus.alu_A !== 64'd5 || bus.alu_B !== 64'd3 || bus.r0_resp_valid !== 1'b0) begin
      bad++; $display("FAIL single_exec: got busy=%b A=%0d B=%0d rv=%b want 1 5 3 0",
                      bus.busy, bus.alu_A, bus.alu_B, bus.r0_resp_valid);
    end
    @(negedge clk);
    #1;
    total++;
    if ({bus.r0_resp_valid, bus.r1_resp_valid, bus.resp_zero} !== 3'b100 || bus.resp_resultado !== 64'd8) begin
      bad++; $display("FAIL single_resp: got rv=%b%b z=%b res=%0d want 10 0 8",
                      bus.r0_resp_valid, bus.r1_resp_valid, bus.resp_zero, bus.resp_resultado);
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.r0_resp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL single_done: got rv=%b busy=%b want 0 0", bus.r0_resp_valid, bus.busy);
    end
  endtask

  // Covers zero subtract, OR with zero operands, and add wrap-around.
  task automatic test_flags();
    logic [63:0] a_t [3];
    logic [1:0]  s_t [3];
    logic [63:0] r_t [3];
    logic        z_t [3];
    a_t = '{64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
    s_t = '{2'b01, 2'b11, 2'b00};
    r_t = '{64'd0, 64'd0, 64'd0};
    z_t = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.r1_valid = 1; bus.r1_A = a_t[i]; bus.r1_sel = s_t[i];
      bus.r1_B = (i == 2) ? 64'd1 : a_t[i];
      #1;
      total++;
      if ({bus.r0_ready, bus.r1_ready} !== 2'b01) begin
        bad++; $display("FAIL flags%0d_ready: got %b want 01", i, {bus.r0_ready, bus.r1_ready});
      end
      @(negedge clk);
      bus.r1_valid = 0;
      @(negedge clk);
      #1;
      total++;
      if ({bus.r0_resp_valid, bus.r1_resp_valid} !== 2'b01 || bus.resp_resultado !== r_t[i]
          || bus.resp_zero !== z_t[i]) begin
        bad++; $display("FAIL flags%0d_resp: got rv=%b%b res=%h z=%b want 01 %h %b", i,
                        bus.r0_resp_valid, bus.r1_resp_valid, bus.resp_resultado, bus.resp_zero,
                        r_t[i], z_t[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic [63:0] a0 [2], b0 [2], a1 [2], b1 [2];
    logic [1:0]  s0 [2], s1 [2];
    logic [63:0] er [3];
    logic        ez [3];
    int          i0, i1, who, t;
    a0 = '{64'd10, 64'd7};     b0 = '{64'd4, 64'd7};     s0 = '{2'b01, 2'b01};
    a1 = '{64'hFF00, 64'd1};   b1 = '{64'h0FF0, 64'd2};  s1 = '{2'b10, 2'b11};
    er = '{64'd6, 64'h0F00, 64'd0};
    ez = '{1'b0, 1'b0, 1'b1};
    i0 = 0; i1 = 0;
    do_reset();
    bus.r0_valid = 1; bus.r1_valid = 1;
    for (int g = 0; g < 3; g++) begin
      bus.r0_A = a0[i0]; bus.r0_B = b0[i0]; bus.r0_sel = s0[i0];
      bus.r1_A = a1[i1]; bus.r1_B = b1[i1]; bus.r1_sel = s1[i1];
      #1;
      t = 0;
      while (!(bus.r0_ready || bus.r1_ready) && t < 6) begin
        @(negedge clk); #1; t++;
      end
      who = bus.r1_ready ? 1 : 0;
      total++;
      if (t >= 6 || who != (g % 2) || (bus.r0_ready && bus.r1_ready)) begin
        bad++; $display("FAIL contention_grant%0d: got r0=%b r1=%b want r%0d", g,
                        bus.r0_ready, bus.r1_ready, g % 2);
      end
      @(negedge clk);
      if (who == 1) begin
        i1 = 1;
        bus.r1_A = a1[i1]; bus.r1_B = b1[i1]; bus.r1_sel = s1[i1];
      end else begin
        i0 = (i0 == 0) ? 1 : 0;
        bus.r0_A = a0[i0]; bus.r0_B = b0[i0]; bus.r0_sel = s0[i0];
      end
      #1;
      t = 0;
      while (!(bus.r0_resp_valid || bus.r1_resp_valid) && t < 6) begin
        @(negedge clk); #1; t++;
      end
      total++;
      if (t >= 6 || {bus.r1_resp_valid, bus.r0_resp_valid} !== (who == 1 ? 2'b10 : 2'b01)
          || bus.resp_resultado !== er[g] || bus.resp_zero !== ez[g]) begin
        bad++; $display("FAIL contention_resp%0d: got rv=%b%b res=%h z=%b want r%0d %h %b", g,
                        bus.r0_resp_valid, bus.r1_resp_valid, bus.resp_resultado, bus.resp_zero,
                        who, er[g], ez[g]);
      end
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bus.r0_valid = 1; bus.r0_A = 64'hF0; bus.r0_B = 64'h3C; bus.r0_sel = 2'b10;
    bus.r0_resp_ready = 0;
    #1;
    total++;
    if (bus.r0_ready !== 1'b1) begin
      bad++; $display("FAIL bp_accept: got %b want 1", bus.r0_ready);
    end
    @(negedge clk);
    bus.r0_valid = 0; bus.r1_valid = 1; bus.r1_A = 64'd1; bus.r1_resp_ready = 1;
    #1;
    total++;
    if (bus.r1_ready !== 1'b0) begin
      bad++; $display("FAIL bp_exec_r1_ready: got %b want 0", bus.r1_ready);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 5) bus.r0_resp_ready = 1;
      #1;
      total++;
      if (bus.r0_resp_valid !== 1'b1 || bus.resp_resultado !== 64'h30 || bus.r1_ready !== 1'b0
          || bus.r1_resp_valid !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d: got rv=%b res=%h r1_ready=%b want 1 30 0", c,
                        bus.r0_resp_valid, bus.resp_resultado, bus.r1_ready);
      end
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.r0_resp_valid !== 1'b0 || bus.r1_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release: got busy=%b rv=%b r1_ready=%b want 0 0 1",
                      bus.busy, bus.r0_resp_valid, bus.r1_ready);
    end
    bus.r1_valid = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    idle_inputs();
    bus.r0_valid = 1; bus.r0_A = 64'hAAAA; bus.r0_B = 64'h5555; bus.r0_sel = 2'b11;
    @(negedge clk);
    bus.r0_valid = 0;
    #1;
    total++;
    if (bus.busy !== 1'b1) begin
      bad++; $display("FAIL midreset_exec: got busy=%b want 1", bus.busy);
    end
    reset = 1;
    @(negedge clk);
    #1;
    total++;
    if ({bus.busy, bus.r0_resp_valid, bus.r1_resp_valid, bus.resp_zero} !== 4'b0000
        || bus.resp_resultado !== 64'd0 || {bus.alu_A, bus.alu_B, bus.alu_sel} !== 130'd0) begin
      bad++; $display("FAIL midreset_state: got busy=%b rv=%b%b res=%h A=%h want all zero",
                      bus.busy, bus.r0_resp_valid, bus.r1_resp_valid, bus.resp_resultado, bus.alu_A);
    end
    reset = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      total++;
      if ({bus.r0_resp_valid, bus.r1_resp_valid, bus.busy} !== 3'b000) begin
        bad++; $display("FAIL midreset_quiet%0d: got rv=%b%b busy=%b want 000", c,
                        bus.r0_resp_valid, bus.r1_resp_valid, bus.busy);
      end
    end
    @(negedge clk);
    bus.r0_valid = 1; bus.r0_A = 64'd2; bus.r0_B = 64'd1; bus.r0_sel = 2'b01;
    bus.r1_valid = 1; bus.r1_A = 64'd9;
    #1;
    total++;
    if ({bus.r0_ready, bus.r1_ready} !== 2'b10) begin
      bad++; $display("FAIL midreset_regrant: got %b want 10", {bus.r0_ready, bus.r1_ready});
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    #1;
    total++;
    if (bus.r0_resp_valid !== 1'b1 || bus.resp_resultado !== 64'd1 || bus.resp_zero !== 1'b0) begin
      bad++; $display("FAIL midreset_result: got rv=%b res=%h z=%b want 1 1 0",
                      bus.r0_resp_valid, bus.resp_resultado, bus.resp_zero);
    end
    @(negedge clk);
  endtask

  // Transaction-level model: who gets granted, what result comes back, and when.
  task automatic test_random();
    logic        ptr_m, busy_m, id_m, e0, e1, exp_rv, z_m;
    logic [63:0] res_m, a_m, b_m;
    logic [1:0]  sel_m;
    int          acc;
    ptr_m = 0; busy_m = 0; id_m = 0; z_m = 0; res_m = 0; a_m = 0; b_m = 0; sel_m = 0; acc = 0;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.r0_valid = 1'($urandom_range(0, 1));
      bus.r1_valid = 1'($urandom_range(0, 1));
      bus.r0_A = rnd(); bus.r0_B = ($urandom_range(0, 3) == 0) ? bus.r0_A : rnd();
      bus.r1_A = rnd(); bus.r1_B = ($urandom_range(0, 3) == 0) ? bus.r1_A : rnd();
      bus.r0_sel = 2'($urandom_range(0, 3));
      bus.r1_sel = 2'($urandom_range(0, 3));
      bus.r0_resp_ready = ($urandom_range(0, 3) != 0);
      bus.r1_resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      e0 = 0; e1 = 0;
      if (!busy_m) begin
        if (bus.r0_valid && bus.r1_valid) begin
          e0 = !ptr_m; e1 = ptr_m;
        end else begin
          e0 = bus.r0_valid; e1 = bus.r1_valid;
        end
      end
      exp_rv = busy_m && (cyc >= acc + 2);
      total++;
      if ({bus.r0_ready, bus.r1_ready} !== {e0, e1}) begin
        bad++; $display("FAIL rand_ready@%0d: got %b want %b", cyc, {bus.r0_ready, bus.r1_ready}, {e0, e1});
      end
      total++;
      if (bus.busy !== busy_m || {bus.r0_resp_valid, bus.r1_resp_valid} !== {exp_rv && !id_m, exp_rv && id_m}) begin
        bad++; $display("FAIL rand_status@%0d: got busy=%b rv=%b%b want %b %b%b", cyc, bus.busy,
                        bus.r0_resp_valid, bus.r1_resp_valid, busy_m, exp_rv && !id_m, exp_rv && id_m);
      end
      if (busy_m) begin
        total++;
        if (bus.alu_A !== a_m || bus.alu_B !== b_m || bus.alu_sel !== sel_m) begin
          bad++; $display("FAIL rand_alu@%0d: got %h %h %b want %h %h %b", cyc,
                          bus.alu_A, bus.alu_B, bus.alu_sel, a_m, b_m, sel_m);
        end
      end
      if (exp_rv) begin
        total++;
        if (bus.resp_resultado !== res_m || bus.resp_zero !== z_m) begin
          bad++; $display("FAIL rand_result@%0d: got %h z=%b want %h z=%b", cyc,
                          bus.resp_resultado, bus.resp_zero, res_m, z_m);
        end
      end
      if (e0 || e1) begin
        busy_m = 1; id_m = e1; acc = cyc; ptr_m = e0;
        a_m   = e1 ? bus.r1_A   : bus.r0_A;
        b_m   = e1 ? bus.r1_B   : bus.r0_B;
        sel_m = e1 ? bus.r1_sel : bus.r0_sel;
        res_m = alu_fn(a_m, b_m, sel_m);
        z_m   = (sel_m == 2'b01) && (res_m == 64'd0);
      end else if (exp_rv && (id_m ? bus.r1_resp_ready : bus.r0_resp_ready)) begin
        busy_m = 0;
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_single();
    test_flags();
    test_contention();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
